sp_ram_nx64_initiator: RTL and testbench
========================================

Name: sp_ram_nx64_initiator

Overview:
- Request-side master for the synchronous single-port Nx64 byte-enable RAM.
- Converts a valid/ready request stream (read, or byte-masked write) into the RAM's chip-select/write-enable/byte-enable/address/data port.
- Tracks the RAM's fixed read latency and returns one in-order response per request through a credit-protected response buffer, so downstream backpressure never loses RAM read data.
- Sits between a bus adapter or DMA engine and the RAM instance.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_DEPTH, 1024, number of valid words. Must be <= 2**ADDR_WIDTH.
- RAM_LATENCY, 1, RAM read latency in cycles. Legal values are 1 or 2 (RAM output regs off/on).
- RSP_DEPTH, 4, response buffer entries. Must be >= 2. Full throughput requires RSP_DEPTH >= RAM_LATENCY+2.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  synchronous active-low reset.
- ReqValid_SI  in  1  request valid.
- ReqReady_SO  out  1  request ready.
- ReqWe_SI  in  1  1=write, 0=read.
- ReqBe_SI  in  8  byte enables; bit i covers bits [8i+7:8i].
- ReqAddr_DI  in  ADDR_WIDTH  word address.
- ReqWData_DI  in  64  write data.
- RspValid_SO  out  1  response valid.
- RspReady_SI  in  1  response ready.
- RspWe_SO  out  1  response belongs to a write.
- RspErr_SO  out  1  address out of range.
- RspRData_DO  out  64  read data; 0 for writes and errors.
- RamCSel_SO  out  1  RAM chip select.
- RamWrEn_SO  out  1  RAM write enable.
- RamBEn_SO  out  8  RAM byte enables.
- RamAddr_DO  out  ADDR_WIDTH  RAM address.
- RamWrData_DO  out  64  RAM write data.
- RamRdData_DI  in  64  RAM read data.
- Idle_SO  out  1  nothing in flight or buffered.

Behaviour:
- Reset (Rst_RBI==0 at a clock edge):
  - Clears credit counter, latency pipeline and response buffer.
  - While Rst_RBI is low, ReqReady_SO=0 and RamCSel_SO=0.
  - After reset: RspValid_SO=0, RspWe_SO=0, RspErr_SO=0, RspRData_DO=0, Idle_SO=1.
  - Reset mid-operation drops in-flight reads and buffered responses; no response is emitted for them.
- Credits:
  - cnt (width clog2(RSP_DEPTH+1)) = accepted requests whose response has not yet been popped.
  - ReqReady_SO = (cnt < RSP_DEPTH), from the registered cnt only. There is no combinational path from RspReady_SI.
  - cnt +1 on accept (ReqValid_SI & ReqReady_SO), -1 on pop (RspValid_SO & RspReady_SI), unchanged when both happen in the same cycle.
  - cnt never exceeds RSP_DEPTH and never underflows.
- RAM drive (combinational in the accept cycle):
  - inrange = ReqAddr_DI < DATA_DEPTH.
  - RamCSel_SO = accept & inrange.
  - RamWrEn_SO = RamCSel_SO & ReqWe_SI.
  - RamBEn_SO = RamWrEn_SO ? ReqBe_SI : 0.
  - RamAddr_DO = ReqAddr_DI; RamWrData_DO = ReqWData_DI.
  - A write with ReqBe_SI=0 is still issued and still responded to.
- Latency pipeline:
  - RAM_LATENCY-stage shift register of {valid, we, err}, loaded on accept.
  - At stage RAM_LATENCY the entry is pushed into the response buffer with data = (we|err) ? 0 : RamRdData_DI, sampled in exactly that cycle.
- Response buffer:
  - FIFO with registered outputs.
  - Response for a request accepted in cycle t is first visible in cycle t+RAM_LATENCY+1.
  - Strict request order for reads, writes and errors.
  - Push and pop in the same cycle are allowed, including at full or empty.
  - Overflow is impossible by the credit rule; a simulation-only assertion checks this.
- Outputs hold stable while RspValid_SO=1 and RspReady_SI=0.
- Idle_SO = (cnt==0).
- Elaboration check: fatal error if RAM_LATENCY is not in {1,2}, if RSP_DEPTH<2, or if DATA_DEPTH > 2**ADDR_WIDTH.

Test Plan:
1. Reset with ReqValid_SI=1 held -> RamCSel_SO=0 and ReqReady_SO=0 throughout; after release RspValid_SO=0, Idle_SO=1, ReqReady_SO=1.
2. Write addr 5 data 0x1122334455667788 BEn 0xFF, then read addr 5 (RAM_LATENCY=1) -> write response We=1 data 0; read response 0x1122334455667788 exactly 2 cycles after its accept.
3. Write addr 5 data 0xAAAAAAAAAAAAAAAA BEn 0x0F, then read -> 0x11223344AAAAAAAA.
4. 8 back-to-back reads of addr 0..7 (preloaded with value=addr), RspReady_SI=1, RAM_LATENCY=1, RSP_DEPTH=4 -> ReqReady_SO never drops; 8 consecutive responses with data 0..7 in order. Repeat with RAM_LATENCY=2.
5. RspReady_SI=0 while issuing reads -> exactly 4 accepted, then ReqReady_SO=0; release RspReady_SI -> 4 responses in order, none lost or duplicated; ReqReady_SO returns 1 the cycle after the first pop.
6. DATA_DEPTH=1000, read addr 1000 between two valid reads -> RamCSel_SO=0 for it; response Err=1 data 0, order preserved. Reset asserted with 3 responses pending -> none emitted afterwards, Idle_SO=1.

Source files
------------

// File: rtl/sp_ram_nx64_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_nx64_initiator_if
// Description : Request/response stream bundle for the Nx64 RAM initiator.
//               master = client issuing requests and consuming responses,
//               slave  = the initiator itself.
// Signals     : ReqValid_SI/ReqReady_SO   request handshake
//               ReqWe_SI, ReqBe_SI[7:0], ReqAddr_DI[ADDR_WIDTH-1:0],
//               ReqWData_DI[63:0]         request payload
//               RspValid_SO/RspReady_SI   response handshake
//               RspWe_SO, RspErr_SO, RspRData_DO[63:0]  response payload
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_ram_nx64_initiator_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  ReqValid_SI;
    logic                  ReqReady_SO;
    logic                  ReqWe_SI;
    logic [7:0]            ReqBe_SI;
    logic [ADDR_WIDTH-1:0] ReqAddr_DI;
    logic [63:0]           ReqWData_DI;
    logic                  RspValid_SO;
    logic                  RspReady_SI;
    logic                  RspWe_SO;
    logic                  RspErr_SO;
    logic [63:0]           RspRData_DO;

    modport master (
        output ReqValid_SI, ReqWe_SI, ReqBe_SI, ReqAddr_DI, ReqWData_DI, RspReady_SI,
        input  ReqReady_SO, RspValid_SO, RspWe_SO, RspErr_SO, RspRData_DO
    );

    modport slave (
        input  ReqValid_SI, ReqWe_SI, ReqBe_SI, ReqAddr_DI, ReqWData_DI, RspReady_SI,
        output ReqReady_SO, RspValid_SO, RspWe_SO, RspErr_SO, RspRData_DO
    );
endinterface
`default_nettype wire

// File: rtl/sp_ram_nx64_initiator.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_nx64_initiator
// Description : Request-side master for a synchronous single-port Nx64
//               byte-enable RAM. Turns a valid/ready request stream into RAM
//               strobes, tracks the fixed RAM read latency and returns one
//               in-order response per request through a credit-protected
//               response buffer.
// Ports       : Clk_CI            clock
//               Rst_RBI           synchronous active-low reset
//               Bus (slave)       request/response streams
//               RamCSel_SO        RAM chip select
//               RamWrEn_SO        RAM write enable
//               RamBEn_SO[7:0]    RAM byte enables
//               RamAddr_DO        RAM word address
//               RamWrData_DO[63:0] RAM write data
//               RamRdData_DI[63:0] RAM read data
//               Idle_SO           nothing in flight or buffered
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_nx64_initiator #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_DEPTH  = 1024,
    parameter int RAM_LATENCY = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  wire logic                  Clk_CI,
    input  wire logic                  Rst_RBI,
    sp_ram_nx64_initiator_if.slave     Bus,
    output logic                       RamCSel_SO,
    output logic                       RamWrEn_SO,
    output logic [7:0]                 RamBEn_SO,
    output logic [ADDR_WIDTH-1:0]      RamAddr_DO,
    output logic [63:0]                RamWrData_DO,
    input  wire logic [63:0]           RamRdData_DI,
    output logic                       Idle_SO
);

    generate
        if ((RAM_LATENCY < 1) || (RAM_LATENCY > 2) || (RSP_DEPTH < 2) ||
            (DATA_DEPTH > (2 ** ADDR_WIDTH))) begin : g_param_check
            $fatal(1, "sp_ram_nx64_initiator: illegal parameter combination");
        end
    endgenerate

    // The response buffer is one output register plus a small store holding
    // the remaining RSP_DEPTH-1 entries.
    localparam int c_CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam int c_ST_DEPTH = RSP_DEPTH - 1;
    localparam int c_ST_PTR_W = (c_ST_DEPTH > 1) ? $clog2(c_ST_DEPTH) : 1;
    localparam int c_ST_CNT_W = $clog2(c_ST_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]    c_CNT_MAX  = c_CNT_W'(RSP_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [c_ST_PTR_W-1:0] c_ST_LAST  = c_ST_PTR_W'(c_ST_DEPTH - 1);
    localparam logic [c_ST_CNT_W-1:0] c_ST_FULL  = c_ST_CNT_W'(c_ST_DEPTH);

    // ------------------------------------------------------------------
    // Credits: one per accepted request until its response is popped.
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_pop;
    logic               w_inrange;
    logic               r_out_valid;

    assign w_req_ready = Rst_RBI & (r_cnt < c_CNT_MAX);
    assign w_accept    = Bus.ReqValid_SI & w_req_ready;
    assign w_pop       = r_out_valid & Bus.RspReady_SI;
    assign w_inrange   = ({1'b0, Bus.ReqAddr_DI} < c_DEPTH);

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign Bus.ReqReady_SO = w_req_ready;
    assign Idle_SO         = (r_cnt == '0);

    // ------------------------------------------------------------------
    // RAM drive, combinational in the accept cycle.
    // ------------------------------------------------------------------
    assign RamCSel_SO   = w_accept & w_inrange;
    assign RamWrEn_SO   = RamCSel_SO & Bus.ReqWe_SI;
    assign RamBEn_SO    = RamWrEn_SO ? Bus.ReqBe_SI : 8'h00;
    assign RamAddr_DO   = Bus.ReqAddr_DI;
    assign RamWrData_DO = Bus.ReqWData_DI;

    // ------------------------------------------------------------------
    // Latency pipeline: the last stage lines up with valid RAM read data.
    // ------------------------------------------------------------------
    logic [RAM_LATENCY-1:0] r_lat_vld;
    logic [RAM_LATENCY-1:0] r_lat_we;
    logic [RAM_LATENCY-1:0] r_lat_err;

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_lat_vld <= '0;
        end else begin
            r_lat_vld[0] <= w_accept;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_lat_vld[i] <= r_lat_vld[i-1];
            end
        end
    end

    // Payload bits are qualified by r_lat_vld and need no reset.
    always_ff @(posedge Clk_CI) begin
        r_lat_we[0]  <= Bus.ReqWe_SI;
        r_lat_err[0] <= ~w_inrange;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            r_lat_we[i]  <= r_lat_we[i-1];
            r_lat_err[i] <= r_lat_err[i-1];
        end
    end

    logic        w_push;
    logic [65:0] w_push_entry;

    assign w_push       = r_lat_vld[RAM_LATENCY-1];
    assign w_push_entry = {r_lat_we[RAM_LATENCY-1], r_lat_err[RAM_LATENCY-1],
                           (r_lat_we[RAM_LATENCY-1] | r_lat_err[RAM_LATENCY-1]) ?
                           64'h0 : RamRdData_DI};

    // ------------------------------------------------------------------
    // Response buffer: registered head plus a circular store behind it.
    // An entry only enters the store when the head is occupied, so the
    // oldest response is always in the head register.
    // ------------------------------------------------------------------
    logic                  r_out_we;
    logic                  r_out_err;
    logic [63:0]           r_out_data;
    logic [65:0]           r_st_mem [c_ST_DEPTH];
    logic [c_ST_PTR_W-1:0] r_st_wr;
    logic [c_ST_PTR_W-1:0] r_st_rd;
    logic [c_ST_CNT_W-1:0] r_st_cnt;
    logic                  w_out_free;
    logic                  w_st_empty;
    logic                  w_st_push;
    logic                  w_st_pop;

    assign w_out_free = ~r_out_valid | w_pop;
    assign w_st_empty = (r_st_cnt == '0);
    assign w_st_pop   = w_out_free & ~w_st_empty;
    assign w_st_push  = w_push & ~(w_out_free & w_st_empty);

    function automatic logic [c_ST_PTR_W-1:0] f_ptr_inc(input logic [c_ST_PTR_W-1:0] p);
        return (p == c_ST_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_out_free) begin
            if (!w_st_empty) begin
                r_out_valid                        <= 1'b1;
                {r_out_we, r_out_err, r_out_data}  <= r_st_mem[r_st_rd];
            end else if (w_push) begin
                r_out_valid                        <= 1'b1;
                {r_out_we, r_out_err, r_out_data}  <= w_push_entry;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (w_st_push) begin
            r_st_mem[r_st_wr] <= w_push_entry;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_st_wr  <= '0;
            r_st_rd  <= '0;
            r_st_cnt <= '0;
        end else begin
            if (w_st_push) begin
                r_st_wr <= f_ptr_inc(r_st_wr);
            end
            if (w_st_pop) begin
                r_st_rd <= f_ptr_inc(r_st_rd);
            end
            if (w_st_push && !w_st_pop) begin
                r_st_cnt <= r_st_cnt + 1'b1;
            end else if (!w_st_push && w_st_pop) begin
                r_st_cnt <= r_st_cnt - 1'b1;
            end
        end
    end

    assign Bus.RspValid_SO = r_out_valid;
    assign Bus.RspWe_SO    = r_out_we;
    assign Bus.RspErr_SO   = r_out_err;
    assign Bus.RspRData_DO = r_out_data;

    // The credit limit must keep the store from ever overflowing.
    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        !(w_st_push && !w_st_pop && (r_st_cnt == c_ST_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_nx64_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_nx64_initiator
// Description : Scoreboard bench for sp_ram_nx64_initiator. Instance A uses
//               RAM_LATENCY=1 / DATA_DEPTH=1000, instance B RAM_LATENCY=2 /
//               DATA_DEPTH=1024; both sit on behavioural RAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_nx64_initiator;
    localparam int AW = 10;

    typedef struct {
        logic        we;
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           sel;
    logic           req_valid;
    logic           req_we;
    logic [7:0]     req_be;
    logic [AW-1:0]  req_addr;
    logic [63:0]    req_wdata;
    logic           rsp_rdy_a;
    logic           rsp_rdy_b;
    logic           chk_lat;
    int             cyc = 0;
    int             n_vec = 0;
    int             n_err = 0;
    int             n_stall = 0;
    exp_t           q_a[$];
    exp_t           q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_nx64_initiator_if #(.ADDR_WIDTH(AW)) bus_a ();
    sp_ram_nx64_initiator_if #(.ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.ReqValid_SI = req_valid & ~sel;
    assign bus_a.ReqWe_SI    = req_we;
    assign bus_a.ReqBe_SI    = req_be;
    assign bus_a.ReqAddr_DI  = req_addr;
    assign bus_a.ReqWData_DI = req_wdata;
    assign bus_a.RspReady_SI = rsp_rdy_a;
    assign bus_b.ReqValid_SI = req_valid & sel;
    assign bus_b.ReqWe_SI    = req_we;
    assign bus_b.ReqBe_SI    = req_be;
    assign bus_b.ReqAddr_DI  = req_addr;
    assign bus_b.ReqWData_DI = req_wdata;
    assign bus_b.RspReady_SI = rsp_rdy_b;

    logic          cs_a, wen_a, idle_a, cs_b, wen_b, idle_b;
    logic [7:0]    ben_a, ben_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [63:0]   wd_a, wd_b, rd_a, rd_b1, rd_b2;

    sp_ram_nx64_initiator #(.ADDR_WIDTH(AW), .DATA_DEPTH(1000), .RAM_LATENCY(1), .RSP_DEPTH(4)) dut_a (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Bus(bus_a.slave),
        .RamCSel_SO(cs_a), .RamWrEn_SO(wen_a), .RamBEn_SO(ben_a), .RamAddr_DO(addr_a),
        .RamWrData_DO(wd_a), .RamRdData_DI(rd_a), .Idle_SO(idle_a)
    );

    sp_ram_nx64_initiator #(.ADDR_WIDTH(AW), .DATA_DEPTH(1024), .RAM_LATENCY(2), .RSP_DEPTH(4)) dut_b (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Bus(bus_b.slave),
        .RamCSel_SO(cs_b), .RamWrEn_SO(wen_b), .RamBEn_SO(ben_b), .RamAddr_DO(addr_b),
        .RamWrData_DO(wd_b), .RamRdData_DI(rd_b2), .Idle_SO(idle_b)
    );

    // Behavioural RAMs: A has one read register, B an extra output register.
    logic [63:0] mem_a [0:1023];
    logic [63:0] mem_b [0:1023];

    always @(posedge clk) begin
        if (cs_a) begin
            if (wen_a) begin
                for (int i = 0; i < 8; i++) if (ben_a[i]) mem_a[addr_a][8*i +: 8] <= wd_a[8*i +: 8];
            end else begin
                rd_a <= mem_a[addr_a];
            end
        end
    end

    always @(posedge clk) begin
        rd_b2 <= rd_b1;
        if (cs_b) begin
            if (wen_b) begin
                for (int i = 0; i < 8; i++) if (ben_b[i]) mem_b[addr_b][8*i +: 8] <= wd_b[8*i +: 8];
            end else begin
                rd_b1 <= mem_b[addr_b];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever a response handshake occurs and
    // verifies that stalled responses hold still.
    // ------------------------------------------------------------------
    logic        stall  [2];
    logic [2:0]  hold_f [2];
    logic [63:0] hold_d [2];

    task automatic monitor(input logic s);
        logic v, r;
        logic [2:0] f;
        logic [63:0] d;
        exp_t e;
        string p;
        p = s ? "b" : "a";
        v = s ? bus_b.RspValid_SO : bus_a.RspValid_SO;
        r = s ? rsp_rdy_b : rsp_rdy_a;
        f = s ? {bus_b.RspValid_SO, bus_b.RspWe_SO, bus_b.RspErr_SO}
              : {bus_a.RspValid_SO, bus_a.RspWe_SO, bus_a.RspErr_SO};
        d = s ? bus_b.RspRData_DO : bus_a.RspRData_DO;
        if (!rst_n) begin
            stall[s] = 1'b0;
            return;
        end
        if (stall[s]) begin
            check({p, "_hold_flags"}, 64'(f), 64'(hold_f[s]));
            check({p, "_hold_data"}, d, hold_d[s]);
        end
        if (v && r) begin
            if ((s ? q_b.size() : q_a.size()) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_unexpected_rsp: got data %h, expected no response", p, d);
            end else begin
                if (s) e = q_b.pop_front();
                else   e = q_a.pop_front();
                check({p, "_rsp_we"}, 64'(f[1]), 64'(e.we));
                check({p, "_rsp_err"}, 64'(f[0]), 64'(e.err));
                check({p, "_rsp_data"}, d, e.data);
                if (e.cyc >= 0) check({p, "_rsp_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
        stall[s]  = v & ~r;
        hold_f[s] = f;
        hold_d[s] = d;
    endtask

    always @(negedge clk) begin
        monitor(1'b0);
        monitor(1'b1);
    end

    // ------------------------------------------------------------------
    // Driver: holds a request until accepted; checks the RAM strobes in the
    // accept cycle and queues the hand-computed response.
    // ------------------------------------------------------------------
    task automatic send(input logic s, input logic we, input logic [7:0] be, input logic [AW-1:0] addr,
                        input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
        exp_t e;
        int   waited = 0;
        logic ok = 1'b0;
        sel = s; req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (s ? bus_b.ReqReady_SO : bus_a.ReqReady_SO) begin
                ok = 1'b1;
                check("ram_csel", 64'(s ? cs_b : cs_a), 64'(!exp_err));
                check("ram_wren", 64'(s ? wen_b : wen_a), 64'(!exp_err && we));
                check("ram_ben", 64'(s ? ben_b : ben_a), (!exp_err && we) ? 64'(be) : 64'h0);
                if (!exp_err) begin
                    check("ram_addr", 64'(s ? addr_b : addr_a), 64'(addr));
                    if (we) check("ram_wdata", s ? wd_b : wd_a, wd);
                end
                e.we = we; e.err = exp_err; e.data = exp_rd;
                e.cyc = chk_lat ? cyc + (s ? 2 : 1) + 1 : -1;
                if (s) q_b.push_back(e);
                else   q_a.push_back(e);
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: request to addr %0d not accepted, required acceptance", addr);
        end
        n_stall += waited;
        req_valid = 1'b0;
    endtask

    task automatic drain(input logic s);
        int n = 0;
        while (((s ? idle_b : idle_a) == 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(s ? "b_drain_idle" : "a_drain_idle", 64'(s ? idle_b : idle_a), 64'h1);
        check(s ? "b_drain_queue" : "a_drain_queue", 64'(s ? q_b.size() : q_a.size()), 64'h0);
        check(s ? "b_drain_valid" : "a_drain_valid", 64'(s ? bus_b.RspValid_SO : bus_a.RspValid_SO), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stall[0] = 1'b0; stall[1] = 1'b0;
        rst_n = 1'b0; sel = 1'b0; chk_lat = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_be = 8'h00; req_addr = '0; req_wdata = '0;
        rsp_rdy_a = 1'b1; rsp_rdy_b = 1'b1;

        // Reset with a request held valid.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready_a", 64'(bus_a.ReqReady_SO), 64'h0);
            check("rst_csel_a", 64'(cs_a), 64'h0);
            check("rst_ready_b", 64'(bus_b.ReqReady_SO), 64'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(bus_a.RspValid_SO), 64'h0);
        check("post_rst_we", 64'(bus_a.RspWe_SO), 64'h0);
        check("post_rst_err", 64'(bus_a.RspErr_SO), 64'h0);
        check("post_rst_data", bus_a.RspRData_DO, 64'h0);
        check("post_rst_idle", 64'(idle_a), 64'h1);
        check("post_rst_ready", 64'(bus_a.ReqReady_SO), 64'h1);
        check("post_rst_ready_b", 64'(bus_b.ReqReady_SO), 64'h1);
        @(posedge clk); #1;

        // Full write then read, with latency check; then partial write.
        chk_lat = 1'b1;
        send(0, 1, 8'hFF, 10'd5, 64'h1122334455667788, 0, 64'h0);
        send(0, 0, 8'h00, 10'd5, 64'h0, 0, 64'h1122334455667788);
        send(0, 1, 8'h0F, 10'd5, 64'hAAAAAAAAAAAAAAAA, 0, 64'h0);
        send(0, 0, 8'h00, 10'd5, 64'h0, 0, 64'h11223344AAAAAAAA);
        send(0, 1, 8'h00, 10'd5, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0);
        send(0, 0, 8'h00, 10'd5, 64'h0, 0, 64'h11223344AAAAAAAA);
        drain(0);

        // Preload 0..7 with value = address, then a back-to-back read burst.
        for (int i = 0; i < 8; i++) send(0, 1, 8'hFF, AW'(i), 64'(i), 0, 64'h0);
        n_stall = 0;
        for (int i = 0; i < 8; i++) send(0, 0, 8'h00, AW'(i), 64'h0, 0, 64'(i));
        check("a_burst_stalls", 64'(n_stall), 64'h0);
        drain(0);

        // Backpressure: four credits, then ready drops until the first pop.
        chk_lat = 1'b0;
        rsp_rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 0, 8'h00, AW'(i + 3), 64'h0, 0, 64'(i + 3));
        repeat (3) begin
            @(negedge clk);
            check("a_full_ready", 64'(bus_a.ReqReady_SO), 64'h0);
            check("a_full_idle", 64'(idle_a), 64'h0);
        end
        @(posedge clk); #1;
        rsp_rdy_a = 1'b1;
        @(negedge clk);
        check("a_pop_valid", 64'(bus_a.RspValid_SO), 64'h1);
        check("a_ready_in_pop_cycle", 64'(bus_a.ReqReady_SO), 64'h0);
        @(negedge clk);
        check("a_ready_after_pop", 64'(bus_a.ReqReady_SO), 64'h1);
        @(posedge clk); #1;
        send(0, 0, 8'h00, 10'd7, 64'h0, 0, 64'h7);
        drain(0);

        // Out-of-range read between two valid reads.
        chk_lat = 1'b1;
        send(0, 0, 8'h00, 10'd3, 64'h0, 0, 64'h3);
        send(0, 0, 8'h00, 10'd1000, 64'h0, 1, 64'h0);
        send(0, 1, 8'hFF, 10'd1023, 64'h5, 1, 64'h0);
        send(0, 0, 8'h00, 10'd4, 64'h0, 0, 64'h4);
        drain(0);

        // Instance B: RAM_LATENCY=2 burst.
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) send(1, 1, 8'hFF, AW'(i), 64'(i), 0, 64'h0);
        chk_lat = 1'b1;
        n_stall = 0;
        for (int i = 0; i < 8; i++) send(1, 0, 8'h00, AW'(i), 64'h0, 0, 64'(i));
        check("b_burst_stalls", 64'(n_stall), 64'h0);
        drain(1);

        // Reset with three responses pending: none may appear afterwards.
        chk_lat = 1'b0;
        rsp_rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 0, 8'h00, AW'(i), 64'h0, 0, 64'(i));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q_a.delete();
        sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_ready", 64'(bus_a.ReqReady_SO), 64'h0);
            check("mid_rst_csel", 64'(cs_a), 64'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; rsp_rdy_a = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 64'(idle_a), 64'h1);
        check("mid_rst_valid", 64'(bus_a.RspValid_SO), 64'h0);
        repeat (10) @(negedge clk);
        check("mid_rst_idle_late", 64'(idle_a), 64'h1);
        check("mid_rst_queue", 64'(q_a.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
